// File: rtl/warmboot_sched.sv
// warmboot_sched: sole owner of the iCE40 SB_WARMBOOT primitive.
// Arbitrates up to N_REQ reboot requesters by fixed priority (index 0 highest),
// runs a cancellable 2^DELAY_TW-cycle grace period that inhibit can freeze,
// presents the image select one cycle ahead of the sticky BOOT pulse.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req[N_REQ]       per-requester reboot request (pulse or level)
//   req_sel[2*N_REQ] image for requester i at [2i+1:2i]
//   cancel           abort a pending request during grace
//   inhibit          defer acceptance / freeze the grace counter
//   grant[N_REQ]     one-hot current owner of the pending reboot
//   pending          a request is latched
//   wb_sel, wb_boot  drive the warmboot primitive (S1,S0 / BOOT)
module warmboot_sched #(
  parameter int N_REQ    = 3,
  parameter int DELAY_TW = 16,
  parameter bit USE_PRIM = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] req_sel,
  input  logic               cancel,
  input  logic               inhibit,
  output logic [N_REQ-1:0]   grant,
  output logic               pending,
  output logic [1:0]         wb_sel,
  output logic               wb_boot
);

  typedef enum logic [1:0] {IDLE, GRACE, SETUP, FIRE} state_t;

  state_t              state, state_n;
  logic [DELAY_TW-1:0] cnt, cnt_n;
  logic [1:0]          sel, sel_n;
  logic [N_REQ-1:0]    own, own_n;

  // Isolate the lowest set bit: v & -v.
  function automatic logic [N_REQ-1:0] lowest(input logic [N_REQ-1:0] v);
    return v & (~v + N_REQ'(1));
  endfunction

  function automatic logic [1:0] sel_of(input logic [N_REQ-1:0] oh,
                                        input logic [2*N_REQ-1:0] s);
    logic [1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      if (oh[i]) r = s[2*i +: 2];
    return r;
  endfunction

  logic [N_REQ-1:0] pick_any;
  logic [N_REQ-1:0] pick_pre;

  // own - 1 on a one-hot owner yields exactly the higher-priority indices.
  assign pick_any = lowest(req);
  assign pick_pre = lowest(req & (own - N_REQ'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= '0;
      own   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
      own   <= own_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    own_n   = own;
    case (state)
      IDLE: begin
        if (|req && !inhibit) begin
          own_n   = pick_any;
          sel_n   = sel_of(pick_any, req_sel);
          cnt_n   = '0;
          state_n = GRACE;
        end
      end
      GRACE: begin
        if (cancel) begin
          state_n = IDLE;
          own_n   = '0;
          sel_n   = '0;
          cnt_n   = '0;
        end else if (|pick_pre) begin
          own_n = pick_pre;
          sel_n = sel_of(pick_pre, req_sel);
          cnt_n = '0;
        end else if (inhibit) begin
          cnt_n = cnt;
        end else if (cnt == '1) begin
          state_n = SETUP;
        end else begin
          cnt_n = cnt + DELAY_TW'(1);
        end
      end
      SETUP:   state_n = FIRE;
      FIRE:    state_n = FIRE;
      default: state_n = IDLE;
    endcase
  end

  // sel and own are cleared whenever IDLE is entered, so they read zero there.
  assign grant   = own;
  assign wb_sel  = sel;
  assign pending = (state != IDLE);
  assign wb_boot = (state == FIRE);

  generate
    if (USE_PRIM) begin : g_prim
`ifdef SYNTHESIS
      SB_WARMBOOT u_warmboot (
        .BOOT (wb_boot),
        .S1   (wb_sel[1]),
        .S0   (wb_sel[0])
      );
`endif
    end
  endgenerate

endmodule

// File: tb/tb_warmboot_sched.sv
module tb_warmboot_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [5:0] req_sel;
  logic       cancel;
  logic       inhibit;
  logic [2:0] grant;
  logic       pending;
  logic [1:0] wb_sel;
  logic       wb_boot;

  int checks = 0;
  int errors = 0;

  warmboot_sched #(.N_REQ(3), .DELAY_TW(2), .USE_PRIM(1'b0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_sel (req_sel),
    .cancel  (cancel),
    .inhibit (inhibit),
    .grant   (grant),
    .pending (pending),
    .wb_sel  (wb_sel),
    .wb_boot (wb_boot)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts reset mid-cycle, checks the outputs cleared asynchronously, releases.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, pending, wb_sel, wb_boot} !== 7'b0) begin
      errors++;
      $display("FAIL %s_async_reset: outputs=%b required=0000000", tag,
               {grant, pending, wb_sel, wb_boot});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_sel = '0; cancel = 1'b0; inhibit = 1'b0;
    #12;
    checks++;
    if ({grant, pending, wb_sel, wb_boot} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b required=0000000",
               {grant, pending, wb_sel, wb_boot});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    req = 3'b010; req_sel = 6'b00_01_00;
    step();                      // E0
    req = '0;
    checks++;
    if (grant !== 3'b010 || pending !== 1'b1 || wb_sel !== 2'b01) begin
      errors++;
      $display("FAIL basic_accept: grant=%b pending=%b sel=%b required 010/1/01",
               grant, pending, wb_sel);
    end
    step(4);                     // after E4 (SETUP)
    checks++;
    if (wb_boot !== 1'b0 || pending !== 1'b1 || wb_sel !== 2'b01) begin
      errors++;
      $display("FAIL basic_setup: boot=%b pending=%b sel=%b required 0/1/01",
               wb_boot, pending, wb_sel);
    end
    step();                      // after E5
    checks++;
    if (wb_boot !== 1'b1) begin
      errors++;
      $display("FAIL basic_fire: boot=%b required 1", wb_boot);
    end
    for (int k = 0; k < 20; k++) begin
      req = 3'b001; cancel = k[0]; inhibit = k[1];
      step();
      checks++;
      if (wb_boot !== 1'b1 || wb_sel !== 2'b01 || grant !== 3'b010) begin
        errors++;
        $display("FAIL basic_sticky_%0d: boot=%b sel=%b grant=%b required 1/01/010",
                 k, wb_boot, wb_sel, grant);
      end
    end
    req = '0; cancel = 1'b0; inhibit = 1'b0;
    pulse_reset("fire");
  endtask

  task automatic test_simultaneous();
    req = 3'b110; req_sel = 6'b10_01_11;
    step();                      // E0
    req = '0;
    checks++;
    if (grant !== 3'b010 || wb_sel !== 2'b01) begin
      errors++;
      $display("FAIL simul_pick: grant=%b sel=%b required 010/01", grant, wb_sel);
    end
    step();                      // E1
    req = 3'b001;
    step();                      // E2 preempt
    req = '0;
    checks++;
    if (grant !== 3'b001 || wb_sel !== 2'b11) begin
      errors++;
      $display("FAIL simul_preempt: grant=%b sel=%b required 001/11", grant, wb_sel);
    end
    step(4);
    checks++;
    if (wb_boot !== 1'b0) begin
      errors++;
      $display("FAIL simul_early: boot=%b required 0 after E2+4", wb_boot);
    end
    step();
    checks++;
    if (wb_boot !== 1'b1 || wb_sel !== 2'b11) begin
      errors++;
      $display("FAIL simul_fire: boot=%b sel=%b required 1/11 after E2+5", wb_boot, wb_sel);
    end
    pulse_reset("simul");
  endtask

  task automatic test_lower_ignored();
    req = 3'b001; req_sel = 6'b10_01_11;
    step();                      // E0
    req = 3'b100;
    step();                      // E1
    req = '0;
    checks++;
    if (grant !== 3'b001 || wb_sel !== 2'b11) begin
      errors++;
      $display("FAIL lower_ignored: grant=%b sel=%b required 001/11", grant, wb_sel);
    end
    step(3);                     // after E4
    checks++;
    if (wb_boot !== 1'b0 || grant !== 3'b001) begin
      errors++;
      $display("FAIL lower_early: boot=%b grant=%b required 0/001", wb_boot, grant);
    end
    step();                      // after E5
    checks++;
    if (wb_boot !== 1'b1) begin
      errors++;
      $display("FAIL lower_fire: boot=%b required 1", wb_boot);
    end
    pulse_reset("lower");
  endtask

  task automatic test_cancel();
    req = 3'b010; req_sel = 6'b10_01_11;
    step();                      // E0
    req = '0;
    step();                      // E1
    cancel = 1'b1; req = 3'b001;
    step();                      // E2
    cancel = 1'b0; req = 3'b100;
    checks++;
    if (pending !== 1'b0 || grant !== 3'b000 || wb_sel !== 2'b00 || wb_boot !== 1'b0) begin
      errors++;
      $display("FAIL cancel_clear: pending=%b grant=%b sel=%b boot=%b required 0/000/00/0",
               pending, grant, wb_sel, wb_boot);
    end
    step();                      // E3 new accept
    req = '0;
    checks++;
    if (grant !== 3'b100 || wb_sel !== 2'b10 || pending !== 1'b1) begin
      errors++;
      $display("FAIL cancel_reaccept: grant=%b sel=%b pending=%b required 100/10/1",
               grant, wb_sel, pending);
    end
    step(4);
    checks++;
    if (wb_boot !== 1'b0) begin
      errors++;
      $display("FAIL cancel_early: boot=%b required 0 after E3+4", wb_boot);
    end
    step();
    checks++;
    if (wb_boot !== 1'b1) begin
      errors++;
      $display("FAIL cancel_fire: boot=%b required 1 after E3+5", wb_boot);
    end
    pulse_reset("cancel");
  endtask

  task automatic test_inhibit_idle();
    req = 3'b001; req_sel = 6'b10_01_11; inhibit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (pending !== 1'b0 || grant !== 3'b000) begin
        errors++;
        $display("FAIL inhibit_idle_%0d: pending=%b grant=%b required 0/000", k, pending, grant);
      end
    end
    inhibit = 1'b0;
    step();                      // E0
    req = '0;
    checks++;
    if (pending !== 1'b1 || grant !== 3'b001) begin
      errors++;
      $display("FAIL inhibit_release: pending=%b grant=%b required 1/001", pending, grant);
    end
    step(5);
    checks++;
    if (wb_boot !== 1'b1) begin
      errors++;
      $display("FAIL inhibit_idle_fire: boot=%b required 1 after E0+5", wb_boot);
    end
    pulse_reset("inh_idle");
  endtask

  task automatic test_inhibit_grace();
    req = 3'b010; req_sel = 6'b10_01_11;
    step();                      // E0
    req = '0;
    step();                      // E1
    inhibit = 1'b1;
    step(3);                     // E2..E4 frozen
    inhibit = 1'b0;
    step(3);                     // after E7
    checks++;
    if (wb_boot !== 1'b0 || pending !== 1'b1) begin
      errors++;
      $display("FAIL inhibit_grace_early: boot=%b pending=%b required 0/1 after E0+7",
               wb_boot, pending);
    end
    step();                      // after E8
    checks++;
    if (wb_boot !== 1'b1 || wb_sel !== 2'b01) begin
      errors++;
      $display("FAIL inhibit_grace_fire: boot=%b sel=%b required 1/01 after E0+8",
               wb_boot, wb_sel);
    end
    pulse_reset("inh_grace");
  endtask

  task automatic test_reset_grace();
    req = 3'b001; req_sel = 6'b10_01_11;
    step();                      // E0
    req = '0;
    step();
    pulse_reset("grace");
    req = 3'b100;
    step();                      // fresh E0
    req = '0;
    checks++;
    if (grant !== 3'b100 || wb_sel !== 2'b10) begin
      errors++;
      $display("FAIL rst_fresh_accept: grant=%b sel=%b required 100/10", grant, wb_sel);
    end
    step(4);
    checks++;
    if (wb_boot !== 1'b0) begin
      errors++;
      $display("FAIL rst_fresh_early: boot=%b required 0 after E0+4", wb_boot);
    end
    step();
    checks++;
    if (wb_boot !== 1'b1) begin
      errors++;
      $display("FAIL rst_fresh_fire: boot=%b required 1 after E0+5", wb_boot);
    end
    pulse_reset("final");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_lower_ignored();
    test_cancel();
    test_inhibit_idle();
    test_inhibit_grace();
    test_reset_grace();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
